// File: rtl/frame_byte_serializer.sv
// Streams a stored RGB frame as BGR bytes, bottom row first, under a write/ready handshake.
// Define SER_CHECKSUM_EN to add the frame_sum output (mod-2^16 sum of accepted bytes).
module frame_byte_serializer #(
  parameter int H_RES  = 100,
  parameter int V_RES  = 100,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_rdata,
  output logic [7:0]        FrameDataOut,
  output logic              write,
  input  logic              ready
`ifdef SER_CHECKSUM_EN
  ,
  output logic [15:0]       frame_sum
`endif
);

  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_LAT, S_EMIT, S_FIN} state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [1:0]         idx_q, idx_d;
  logic [23:0]        pix_q, pix_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
    end
  end

  // Outputs decode from the state register so an async reset clears them at once.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    idx_d        = idx_q;
    pix_d        = pix_q;
    busy         = 1'b0;
    done         = 1'b0;
    mem_rd_en    = 1'b0;
    mem_addr     = '0;
    write        = 1'b0;
    FrameDataOut = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d   = ROW_W'(V_RES - 1);
          col_d   = '0;
          idx_d   = '0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = ADDR_W'(32'(row_q) * 32'(H_RES) + 32'(col_q));
        state_d   = S_LAT;
      end
      S_LAT: begin
        busy    = 1'b1;
        pix_d   = mem_rdata;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        busy  = 1'b1;
        write = 1'b1;
        case (idx_q)
          2'd0:    FrameDataOut = pix_q[7:0];
          2'd1:    FrameDataOut = pix_q[15:8];
          default: FrameDataOut = pix_q[23:16];
        endcase
        if (ready) begin
          if (idx_q == 2'd2) begin
            idx_d = '0;
            if (col_q != COL_W'(H_RES - 1)) begin
              col_d   = col_q + 1'b1;
              state_d = S_RD;
            end else if (row_q != '0) begin
              col_d   = '0;
              row_d   = row_q - 1'b1;
              state_d = S_RD;
            end else begin
              state_d = S_FIN;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SER_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      sum_q <= '0;
    end else if (write && ready) begin
      sum_q <= sum_q + 16'(FrameDataOut);
    end
  end

  assign frame_sum = sum_q;
`endif

endmodule

// File: tb/tb_frame_byte_serializer.sv
// Scoreboard bench for frame_byte_serializer: a reference model queues the expected byte
// stream per frame and an independent monitor pops and compares every accepted byte.
module tb_frame_byte_serializer;

  localparam int H  = 12;
  localparam int V  = 9;
  localparam int AW = 7;
  localparam int NB = 3 * H * V;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          ready = 1'b1;
  logic          busy, done, mem_rd_en, write;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_rdata = '0;
  logic [7:0]    FrameDataOut;
`ifdef SER_CHECKSUM_EN
  logic [15:0]   frame_sum;
`endif

  frame_byte_serializer #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .FrameDataOut (FrameDataOut),
    .write        (write),
    .ready        (ready)
`ifdef SER_CHECKSUM_EN
    ,
    .frame_sum    (frame_sum)
`endif
  );

  always #5 clk = ~clk;

  logic [23:0] ram [0:H*V-1];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[int'(mem_addr)];

  logic [7:0]  exp_q[$];
  logic [15:0] exp_sum;
  int unsigned total_cnt = 0;
  int unsigned pass_cnt  = 0;
  int unsigned done_cnt  = 0;
  int unsigned beat_cnt  = 0;
  int unsigned busy_cnt  = 0;
  bit          rand_rdy  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1 ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  initial begin
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_write", 32'(write), 32'd1);
          check("hold_data", 32'(FrameDataOut), 32'(prev_data));
        end
        if (mem_rd_en && write) check("rd_wr_overlap", 32'(mem_rd_en & write), 32'd0);
        if (done) begin
          done_cnt++;
          check("done_busy_low", 32'(busy), 32'd0);
`ifdef SER_CHECKSUM_EN
          check("frame_sum", 32'(frame_sum), 32'(exp_sum));
`endif
        end
        if (busy) busy_cnt++;
        if (write && ready) begin
          beat_cnt++;
          check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("byte", 32'(FrameDataOut), 32'(e));
          end
        end
        prev_stall = write && !ready;
        prev_data  = FrameDataOut;
      end
    end
  end

  task automatic run_frame(input bit formula, input bit rnd, input bit extra, input bit abort);
    int unsigned d0, b0, k0, n;
    logic [23:0] p;
    logic [7:0]  a8;
    for (int a = 0; a < H*V; a++) begin
      a8 = 8'(a);
      ram[a] = formula ? {8'hA0 ^ a8, a8, 8'h5A} : 24'($urandom);
    end
    exp_sum = '0;
    for (int r = V-1; r >= 0; r--) begin
      for (int c = 0; c < H; c++) begin
        p = ram[r*H + c];
        exp_q.push_back(p[7:0]);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[23:16]);
        exp_sum = exp_sum + 16'(p[7:0]) + 16'(p[15:8]) + 16'(p[23:16]);
      end
    end
    rand_rdy = rnd;
    d0 = done_cnt; b0 = beat_cnt; k0 = busy_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (extra) begin
      repeat (9) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    n = 0;
    if (abort) begin
      while (beat_cnt - b0 < NB/2 && n < 20000) begin @(posedge clk); n++; end
      check("abort_reach_timeout", 32'(n < 20000), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("rst_outputs", {busy, done, write, mem_rd_en}, 32'd0);
      check("rst_data", 32'(FrameDataOut), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      exp_q.delete();
      @(posedge clk); #2 reset = 1'b0;
      repeat (5) @(posedge clk);
      check("post_rst_idle", {busy, write, mem_rd_en}, 32'd0);
      return;
    end
    while (done_cnt == d0 && n < 20000) begin @(posedge clk); n++; end
    check("done_timeout", 32'(n < 20000), 32'd1);
    repeat (3) @(posedge clk);
    check("frame_bytes", beat_cnt - b0, NB);
    check("done_once", done_cnt - d0, 32'd1);
    check("queue_empty", exp_q.size(), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    if (!rnd) check("busy_cycles", busy_cnt - k0, 5*H*V);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_quiet", {write, busy, done, mem_rd_en}, 32'd0);
    end
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(1'b1, 1'b1, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1, 1'b1, 1'b0);
    run_frame(1'b0, 1'b1, 1'b0, 1'b1);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/frame_byte_serializer.md
Name: frame_byte_serializer

Overview:
Streams a stored frame as BGR bytes in bottom-up row order (BMP pixel-array order) to the frame sink, which consumes FrameDataOut/write.
Reads one 24-bit RGB pixel at a time from the frame buffer RAM (synchronous read, 1-cycle latency).
Emits 3 bytes per pixel under a write/ready handshake.
Sits between the frame buffer and the image writer stage.

Parameters:
H_RES, 100, pixels per row
V_RES, 100, rows per frame
ADDR_W, 14, frame buffer address width (must satisfy 2^ADDR_W >= H_RES*V_RES)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  1-cycle pulse, begins one frame; ignored while busy
busy  out  1  high from the cycle after an accepted start until done
done  out  1  1-cycle pulse after the last byte of the frame is accepted
mem_rd_en  out  1  frame buffer read strobe
mem_addr  out  ADDR_W  pixel address = row*H_RES + col
mem_rdata  in  24  {R[23:16],G[15:8],B[7:0]}, valid the cycle after mem_rd_en
FrameDataOut  out  8  byte to sink
write  out  1  byte valid
ready  in  1  sink accepts the byte when write && ready

Behaviour:
- Reset (async, any time, including mid-frame): state IDLE; busy, done, write, mem_rd_en = 0; FrameDataOut, mem_addr = 0; row/col/byte counters cleared. No partial frame resumes after reset.
- FSM states: IDLE, RD, LAT, EMIT, FIN.
- IDLE: on start, load row = V_RES-1, col = 0, byte index = 0; go to RD. busy rises next cycle.
- RD: mem_rd_en = 1 and mem_addr = row*H_RES + col, for exactly 1 cycle; go to LAT.
- LAT: capture mem_rdata into pixel register; go to EMIT.
- EMIT: write = 1. FrameDataOut = B, then G, then R for byte index 0/1/2.
  - Byte and write are held stable while ready = 0.
  - On a handshake, advance the byte index.
  - On index 2 accepted:
    - col < H_RES-1: col+1, go to RD.
    - col = H_RES-1 and row > 0: col = 0, row-1, go to RD.
    - col = H_RES-1 and row = 0: go to FIN.
- FIN: done = 1 for 1 cycle, busy = 0 in the same cycle; go to IDLE.
- Throughput with ready held high: 5 cycles per pixel (RD, LAT, 3 EMIT beats).
- Total bytes per frame = 3*H_RES*V_RES (30000 at defaults); the byte count is exact with no padding.
- write is low in RD, LAT, FIN and IDLE. mem_rd_en is never asserted outside RD.
- start during busy (including the FIN cycle) is ignored.
- Address arithmetic is unsigned, ADDR_W wide; the product is computed at full width, then truncated.

Optional Feature:
SER_CHECKSUM_EN:
- Defined: adds output frame_sum [15:0], the mod-2^16 sum of every accepted byte of the current frame.
  - Cleared to 0 on reset and on accepted start.
  - Final value is stable from the done pulse until the next start.
- Undefined: the port and the adder are absent; all other behaviour is identical.

Test Plan:
- Reset then idle, ready = 1, no start -> write, busy, done, mem_rd_en stay 0 for 100 cycles.
- Default params, RAM word at address a = {8'hA0 ^ a[7:0], a[7:0], 8'h5A}, ready = 1, one start -> exactly 30000 write beats.
  - First 3 bytes are from address 9900: 5A, 0xAC, 0x0C.
  - Last 3 bytes are from address 99: 5A, 0x63, 0xC3.
  - done pulses once; busy low afterwards.
- Same run with ready toggling pseudo-randomly -> identical byte sequence; FrameDataOut and write held stable on every ready = 0 cycle.
- Second start pulse 10 cycles after the first -> ignored; still exactly 30000 bytes and one done.
- Assert reset at byte 15000 -> all outputs 0 within the same cycle; a new start afterwards produces a full 30000-byte frame from address 9900.
- SER_CHECKSUM_EN with H_RES = 2, V_RES = 2 and all pixels 0x010203 -> frame_sum = 24 at done.
